axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares one AXI4 read master port between two read clients: S0 is the instruction-fetch page loader and S1 is the data load unit.
//  Each client issues one INCR burst at a time. A 2-way round-robin arbiter grants a client, the block forwards its AR, and it routes R beats back to that client until RLAST.
//  The block sits between the CPU core's fetch/memory stages and the SoC AXI interconnect.
// PARAMETERS
//  ID_W   1   ARID/RID width
//  ADDR_W 32  address width
//  DATA_W 32  data width
// PORTS (Sn_ = S0_ and S1_, one copy per client)
//  CLK         in   1       clock
//  RST         in   1       reset, synchronous, active-high
//  Sn_ARADDR   in   ADDR_W  burst start address
//  Sn_ARLEN    in   8       beats-1
//  Sn_ARVALID  in   1       request; held until Sn_ARREADY
//  Sn_ARREADY  out  1       request accepted
//  Sn_RDATA    out  DATA_W  read data
//  Sn_RRESP    out  2       read response
//  Sn_RLAST    out  1       last beat
//  Sn_RVALID   out  1       beat valid
//  Sn_RREADY   in   1       beat accept
//  M_AXI_ARID/ARADDR/ARLEN/ARVALID  out          registered AR to interconnect
//  M_AXI_ARSIZE/ARBURST/ARCACHE     out  3/2/4   constants 3'b010 / INCR / 4'b0011
//  M_AXI_ARREADY                    in   1       AR accept
//  M_AXI_RID/RDATA/RRESP/RLAST/RVALID  in        R channel
//  M_AXI_RREADY                     out  1       = granted Sn_RREADY in S_DATA, else 0
//  GRANT       out  2       one-hot current owner, 2'b00 when idle
//  PROT_ERR    out  1       sticky: beat count differs from ARLEN+1
// BEHAVIOUR
//  - Reset: state S_IDLE; M_AXI_ARVALID=0, ARADDR/ARLEN/ARID=0; GRANT=0; PROT_ERR=0.
//    last_grant=S1, so S0 wins the first tie. RST mid-burst abandons the burst and returns to S_IDLE.
//  - FSM states: S_IDLE, S_ADDR, S_DATA.
//  - S_IDLE: if any Sn_ARVALID, pick a winner.
//    Only one requests -> that one. Both request -> the one != last_grant.
//    Next edge: latch the winner's ADDR/LEN, set M_AXI_ARID=n, M_AXI_ARVALID=1, GRANT=onehot(n), last_grant=n, beat_cnt=0.
//    Then go to S_ADDR. Latency from ARVALID to M_AXI_ARVALID is 1 cycle.
//  - S_ADDR: hold the AR fields stable.
//    Granted Sn_ARREADY = M_AXI_ARREADY, combinational, only in S_ADDR.
//    On handshake: M_AXI_ARVALID<=0 and go to S_DATA.
//  - S_DATA: mux M_AXI_R* to the granted client; the other client sees RVALID=0.
//    Each RVALID&&RREADY beat increments beat_cnt (9 bits, no wrap).
//    Beat with RLAST: go to S_IDLE and clear GRANT.
//    PROT_ERR<=1 if RLAST arrives with beat_cnt!=ARLEN, or a non-last beat arrives with beat_cnt==ARLEN.
//  - A client is not re-granted in the cycle its burst ends. The earliest new M_AXI_ARVALID is 1 cycle after the S_IDLE entry.
//  - R beats arriving in S_IDLE/S_ADDR are not accepted (RREADY=0).
//  - A client waits at most one burst of the other client (starvation-free).
//  - Sn_ARVALID dropping after it has been latched does not cancel the burst.
//  - M_AXI_RID mismatching the latched ID sets PROT_ERR; the data is still routed.
// STRUCTURE
//  - Shared package cpu_axi_pkg: state encodings, AXI constants (SIZE_4B, BURST_INCR, CACHE_NORM), client indices CLI_IF=0, CLI_MEM=1.
//  - One sub-module rr_arb2: combinational pick from 2 requests plus a last_grant input, giving a one-hot grant.
//  - FSM, AR registers, R mux and beat counter stay in the top module.
// TESTING
//  1 S0 ARADDR=0x1000 ARLEN=0x1f, ARREADY=1 -> M_ARVALID 1 cycle later, ARID=0; 32 beats reach S0 only; GRANT 01->00.
//  2 S0 and S1 request in the same cycle after reset -> S0 granted first; S1 granted after S0's RLAST; S1's ARADDR on M.
//  3 S1 keeps requesting back-to-back while S0 requests once -> grants alternate S1,S0,S1; S0 never waits for more than 1 burst.
//  4 ARREADY held low for 5 cycles -> M AR fields stable and Sn_ARREADY=0 throughout; Sn_ARREADY pulses with the handshake.
//  5 ARLEN=3 but RLAST on beat 2 -> PROT_ERR=1 and sticky; FSM returns to S_IDLE.
//  6 RST asserted at beat 10 of a burst -> next cycle GRANT=0, M_ARVALID=0, M_RREADY=0; a new request is served normally.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// Shared encodings for the CPU-side AXI read path: FSM states, fixed AXI
// attributes and client indices.
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } arb_state_e;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_NORM = 4'b0011;

  localparam logic CLI_IF  = 1'b0;
  localparam logic CLI_MEM = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the client that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) gnt = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between the fetch page loader (S0) and the
// data load unit (S1); one INCR burst in flight at a time.
module axi_rd_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,

  input  logic [ADDR_W-1:0] S0_ARADDR,
  input  logic [7:0]        S0_ARLEN,
  input  logic              S0_ARVALID,
  output logic              S0_ARREADY,
  output logic [DATA_W-1:0] S0_RDATA,
  output logic [1:0]        S0_RRESP,
  output logic              S0_RLAST,
  output logic              S0_RVALID,
  input  logic              S0_RREADY,

  input  logic [ADDR_W-1:0] S1_ARADDR,
  input  logic [7:0]        S1_ARLEN,
  input  logic              S1_ARVALID,
  output logic              S1_ARREADY,
  output logic [DATA_W-1:0] S1_RDATA,
  output logic [1:0]        S1_RRESP,
  output logic              S1_RLAST,
  output logic              S1_RVALID,
  input  logic              S1_RREADY,

  output logic [ID_W-1:0]   M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic [3:0]        M_AXI_ARCACHE,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [ID_W-1:0]   M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,

  output logic [1:0]        GRANT,
  output logic              PROT_ERR
);

  arb_state_e state;
  logic       last_grant;
  logic       gnt_idx;
  logic [8:0] beat_cnt;

  logic [1:0]             req, arb_gnt, ar_ready, r_valid, r_ready;
  logic [1:0][ADDR_W-1:0] cl_addr;
  logic [1:0][7:0]        cl_len;
  logic                   win_idx;
  logic                   beat;

  assign req     = {S1_ARVALID, S0_ARVALID};
  assign r_ready = {S1_RREADY, S0_RREADY};
  assign cl_addr = {S1_ARADDR, S0_ARADDR};
  assign cl_len  = {S1_ARLEN, S0_ARLEN};

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (arb_gnt)
  );

  assign win_idx = arb_gnt[1];
  assign beat    = M_AXI_RVALID & M_AXI_RREADY;

  assign M_AXI_ARSIZE  = SIZE_4B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARCACHE = CACHE_NORM;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_IDLE;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARID    <= '0;
      GRANT         <= 2'b00;
      PROT_ERR      <= 1'b0;
      last_grant    <= CLI_MEM;
      gnt_idx       <= CLI_IF;
      beat_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req) begin
          M_AXI_ARADDR  <= cl_addr[win_idx];
          M_AXI_ARLEN   <= cl_len[win_idx];
          M_AXI_ARID    <= ID_W'(win_idx);
          M_AXI_ARVALID <= 1'b1;
          GRANT         <= onehot2(win_idx);
          last_grant    <= win_idx;
          gnt_idx       <= win_idx;
          beat_cnt      <= '0;
          state         <= S_ADDR;
        end
        S_ADDR: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          state         <= S_DATA;
        end
        S_DATA: if (beat) begin
          if (beat_cnt != 9'h1ff) beat_cnt <= beat_cnt + 9'd1;
          // Early RLAST, or a missing RLAST on the final expected beat.
          if (M_AXI_RLAST ? (beat_cnt != {1'b0, M_AXI_ARLEN})
                          : (beat_cnt == {1'b0, M_AXI_ARLEN}))
            PROT_ERR <= 1'b1;
          if (M_AXI_RID != M_AXI_ARID) PROT_ERR <= 1'b1;
          if (M_AXI_RLAST) begin
            GRANT <= 2'b00;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ar_ready     = '0;
    r_valid      = '0;
    M_AXI_RREADY = 1'b0;
    if (state == S_ADDR) ar_ready[gnt_idx] = M_AXI_ARREADY;
    if (state == S_DATA) begin
      r_valid[gnt_idx] = M_AXI_RVALID;
      M_AXI_RREADY     = r_ready[gnt_idx];
    end
  end

  assign S0_ARREADY = ar_ready[0];
  assign S1_ARREADY = ar_ready[1];
  assign S0_RVALID  = r_valid[0];
  assign S1_RVALID  = r_valid[1];
  assign S0_RDATA   = M_AXI_RDATA;
  assign S1_RDATA   = M_AXI_RDATA;
  assign S0_RRESP   = M_AXI_RRESP;
  assign S1_RRESP   = M_AXI_RRESP;
  assign S0_RLAST   = M_AXI_RLAST;
  assign S1_RLAST   = M_AXI_RLAST;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: inputs change 1ns after CLK rise,
// outputs are sampled 2ns after.
module tb_axi_rd_arbiter;

  logic        CLK, RST;
  logic [31:0] S0_ARADDR, S1_ARADDR;
  logic [7:0]  S0_ARLEN, S1_ARLEN;
  logic        S0_ARVALID, S0_ARREADY, S1_ARVALID, S1_ARREADY;
  logic [31:0] S0_RDATA, S1_RDATA;
  logic [1:0]  S0_RRESP, S1_RRESP;
  logic        S0_RLAST, S0_RVALID, S0_RREADY, S1_RLAST, S1_RVALID, S1_RREADY;
  logic [0:0]  M_AXI_ARID, M_AXI_RID;
  logic [31:0] M_AXI_ARADDR, M_AXI_RDATA;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST, M_AXI_RRESP;
  logic [3:0]  M_AXI_ARCACHE;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]  GRANT;
  logic        PROT_ERR;

  int n_chk = 0;
  int n_pass = 0;

  axi_rd_arbiter dut (
    .CLK(CLK), .RST(RST),
    .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .GRANT(GRANT), .PROT_ERR(PROT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input int c, input logic [31:0] addr, input logic [7:0] len);
    if (c == 0) begin S0_ARADDR = addr; S0_ARLEN = len; S0_ARVALID = 1'b1; end
    else        begin S1_ARADDR = addr; S1_ARLEN = len; S1_ARVALID = 1'b1; end
  endtask

  // Waits for the AR, checks its fields, completes the handshake (ARREADY=1).
  task automatic wait_ar(input int c, input logic [31:0] addr, input logic [7:0] len,
                         input string tag, output int lat);
    lat = 0;
    while (!M_AXI_ARVALID && lat < 20) begin
      tick();
      lat++;
    end
    #1;
    chk({tag, "_arvalid"}, M_AXI_ARVALID, 1'b1);
    chk({tag, "_grant"}, GRANT, (c == 0) ? 2'b01 : 2'b10);
    chk({tag, "_arid"}, M_AXI_ARID, c[0]);
    chk({tag, "_araddr"}, M_AXI_ARADDR, addr);
    chk({tag, "_arlen"}, M_AXI_ARLEN, len);
    chk({tag, "_arready"}, {S1_ARREADY, S0_ARREADY}, (c == 0) ? 2'b01 : 2'b10);
    tick();
    if (c == 0) S0_ARVALID = 1'b0; else S1_ARVALID = 1'b0;
  endtask

  // Drives n beats; RLAST on beat index last_at (-1 = never).
  task automatic burst(input int c, input int n, input int last_at, input logic [0:0] rid,
                       input logic [31:0] base, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RID    = rid;
      M_AXI_RDATA  = base + 32'(i);
      M_AXI_RRESP  = 2'b00;
      M_AXI_RLAST  = (i == last_at);
      #1;
      if (c == 0) begin
        if (!S0_RVALID || S0_RDATA != base + 32'(i) || S0_RLAST != (i == last_at) || S1_RVALID) bad++;
      end else begin
        if (!S1_RVALID || S1_RDATA != base + 32'(i) || S1_RLAST != (i == last_at) || S0_RVALID) bad++;
      end
      if (!M_AXI_RREADY) bad++;
      tick();
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    chk({tag, "_route"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int lat;
    RST = 1'b1;
    S0_ARADDR = '0; S0_ARLEN = '0; S0_ARVALID = 1'b0; S0_RREADY = 1'b1;
    S1_ARADDR = '0; S1_ARLEN = '0; S1_ARVALID = 1'b0; S1_RREADY = 1'b1;
    M_AXI_ARREADY = 1'b1; M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
    M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_grant", GRANT, 2'b00);
    chk("rst_arvalid", M_AXI_ARVALID, 1'b0);
    chk("rst_araddr", M_AXI_ARADDR, 32'h0);
    chk("rst_prot", PROT_ERR, 1'b0);
    chk("consts", {M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE}, {3'b010, 2'b01, 4'b0011});
    tick();

    // 1: single S0 burst of 32 beats
    req(0, 32'h1000, 8'h1f);
    wait_ar(0, 32'h1000, 8'h1f, "t1", lat);
    chk("t1_lat", 64'(lat), 64'd1);
    chk("t1_grant_data", GRANT, 2'b01);
    burst(0, 32, 31, 1'b0, 32'hA000, "t1");
    chk("t1_grant_end", GRANT, 2'b00);
    chk("t1_prot", PROT_ERR, 1'b0);

    // 2: tie after reset goes to S0, then S1
    RST = 1'b1; tick(); RST = 1'b0;
    req(0, 32'h2000, 8'd3);
    req(1, 32'h3000, 8'd3);
    wait_ar(0, 32'h2000, 8'd3, "t2a", lat);
    burst(0, 4, 3, 1'b0, 32'hB000, "t2a");
    wait_ar(1, 32'h3000, 8'd3, "t2b", lat);
    chk("t2b_lat", 64'(lat), 64'd1);
    burst(1, 4, 3, 1'b1, 32'hC000, "t2b");

    // 3: S1 re-requests back-to-back, S0 once -> S1, S0, S1
    req(1, 32'h3100, 8'd1);
    wait_ar(1, 32'h3100, 8'd1, "t3a", lat);
    req(1, 32'h3200, 8'd1);
    req(0, 32'h2100, 8'd1);
    burst(1, 2, 1, 1'b1, 32'hD000, "t3a");
    wait_ar(0, 32'h2100, 8'd1, "t3b", lat);
    chk("t3b_lat", 64'(lat), 64'd1);
    burst(0, 2, 1, 1'b0, 32'hD100, "t3b");
    wait_ar(1, 32'h3200, 8'd1, "t3c", lat);
    burst(1, 2, 1, 1'b1, 32'hD200, "t3c");

    // 4: ARREADY held low for 5 cycles
    M_AXI_ARREADY = 1'b0;
    req(0, 32'h4000, 8'd7);
    tick();
    S0_ARADDR = 32'hDEAD0000;
    S0_ARLEN  = 8'hEE;
    begin
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
        #1;
        if (!M_AXI_ARVALID || M_AXI_ARADDR != 32'h4000 || M_AXI_ARLEN != 8'd7 ||
            M_AXI_ARID != 1'b0 || S0_ARREADY || S1_ARREADY) bad++;
        tick();
      end
      chk("t4_hold", 64'(bad), 64'd0);
    end
    M_AXI_ARREADY = 1'b1;
    #1;
    chk("t4_arready_pulse", {S1_ARREADY, S0_ARREADY}, 2'b01);
    tick();
    S0_ARVALID = 1'b0;
    #1;
    chk("t4_arvalid_drop", M_AXI_ARVALID, 1'b0);
    chk("t4_arready_after", S0_ARREADY, 1'b0);
    burst(0, 8, 7, 1'b0, 32'hE000, "t4");
    chk("t4_prot", PROT_ERR, 1'b0);

    // 5: early RLAST -> sticky PROT_ERR
    req(0, 32'h5000, 8'd3);
    wait_ar(0, 32'h5000, 8'd3, "t5", lat);
    burst(0, 2, 1, 1'b0, 32'hF000, "t5");
    #1;
    chk("t5_prot", PROT_ERR, 1'b1);
    chk("t5_grant", GRANT, 2'b00);
    tick();
    req(1, 32'h5100, 8'd0);
    wait_ar(1, 32'h5100, 8'd0, "t5b", lat);
    burst(1, 1, 0, 1'b1, 32'hF100, "t5b");
    chk("t5_prot_sticky", PROT_ERR, 1'b1);

    // 6: reset mid-burst at beat 10
    req(1, 32'h6000, 8'd15);
    wait_ar(1, 32'h6000, 8'd15, "t6", lat);
    burst(1, 10, -1, 1'b1, 32'h6600, "t6");
    RST = 1'b1;
    tick();
    RST = 1'b0;
    M_AXI_RVALID = 1'b1;
    #1;
    chk("t6_grant", GRANT, 2'b00);
    chk("t6_arvalid", M_AXI_ARVALID, 1'b0);
    chk("t6_rready", M_AXI_RREADY, 1'b0);
    chk("t6_rvalid_idle", {S1_RVALID, S0_RVALID}, 2'b00);
    chk("t6_prot", PROT_ERR, 1'b0);
    M_AXI_RVALID = 1'b0;
    tick();
    req(0, 32'h7000, 8'd1);
    wait_ar(0, 32'h7000, 8'd1, "t6b", lat);
    chk("t6b_lat", 64'(lat), 64'd1);
    burst(0, 2, 1, 1'b0, 32'h7700, "t6b");
    chk("t6b_grant", GRANT, 2'b00);
    chk("t6b_prot", PROT_ERR, 1'b0);

    // RID mismatch flags PROT_ERR but still routes the data
    req(0, 32'h8000, 8'd1);
    wait_ar(0, 32'h8000, 8'd1, "t7", lat);
    burst(0, 2, 1, 1'b1, 32'h8800, "t7");
    chk("t7_prot", PROT_ERR, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
